// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON block assembly buffer.
package ascon_pack;

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        PADBLK
    } buf_state_t;

    localparam logic [7:0] PAD_BYTE = 8'h80;

endpackage

// File: rtl/ascon_word_pad.sv
// Combinational ASCON byte padding of a single word.
// For a last word, bytes at or beyond nbytes are replaced by 0x80 then zeros
// (or only zeros when padding is disabled). pad_placed reports whether the
// 0x80 byte landed inside this word.
module ascon_word_pad
    import ascon_pack::*;
#(
    parameter int WORD_W = 32,
    parameter bit PAD_EN = 1'b1,
    localparam int NBYTES = WORD_W / 8,
    localparam int NB_W   = $clog2(NBYTES) + 1
) (
    input  logic [WORD_W-1:0] word,
    input  logic [NB_W-1:0]   nbytes,
    input  logic              last,
    output logic [WORD_W-1:0] padded,
    output logic              pad_placed
);

    logic [NB_W-1:0] nb_clamped;

    // Clamp the byte count, then overwrite the bytes past the end of the data
    always_comb begin
        nb_clamped = (nbytes > NB_W'(NBYTES)) ? NB_W'(NBYTES) : nbytes;
        padded     = word;
        pad_placed = 1'b0;
        if (last) begin
            pad_placed = PAD_EN && (nb_clamped < NB_W'(NBYTES));
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (NB_W'(i) >= nb_clamped) begin
                    padded[WORD_W-1-8*i -: 8] =
                        (PAD_EN && (NB_W'(i) == nb_clamped)) ? PAD_BYTE : 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/ascon_block_buffer.sv
// Block assembly buffer: gathers WORD_W-bit words into an NB_WORDS-word block,
// applies ASCON padding after the final byte and emits an extra pad-only block
// when a message ends exactly on a block boundary.
module ascon_block_buffer
    import ascon_pack::*;
#(
    parameter int WORD_W   = 32,
    parameter int NB_WORDS = 4,
    parameter bit PAD_EN   = 1'b1
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         clear_i,
    input  logic [WORD_W-1:0]            in_word_i,
    input  logic                         in_valid_i,
    input  logic                         in_last_i,
    input  logic [$clog2(WORD_W/8):0]    in_nbytes_i,
    output logic                         in_ready_o,
    output logic [WORD_W*NB_WORDS-1:0]   blk_o,
    output logic                         blk_valid_o,
    output logic                         blk_last_o,
    input  logic                         blk_ready_i
);

    localparam int BLOCK_W = WORD_W * NB_WORDS;
    localparam int CNT_W   = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

    localparam logic [WORD_W-1:0]  PAD_WORD  = WORD_W'(PAD_BYTE) << (WORD_W - 8);
    localparam logic [BLOCK_W-1:0] PAD_BLOCK = BLOCK_W'(PAD_BYTE) << (BLOCK_W - 8);

    buf_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [BLOCK_W-1:0]  data;
    logic                pad_pending;

    logic [WORD_W-1:0]   padded_word;
    logic                pad_placed;
    logic                last_slot;
    logic                pad_next;
    logic                spill;
    logic [CNT_W:0]      cnt_ext;
    logic [CNT_W:0]      cnt_inc;
    logic [BLOCK_W-1:0]  fill_data;

    ascon_word_pad #(
        .WORD_W (WORD_W),
        .PAD_EN (PAD_EN)
    ) u_word_pad (
        .word       (in_word_i),
        .nbytes     (in_nbytes_i),
        .last       (in_last_i),
        .padded     (padded_word),
        .pad_placed (pad_placed)
    );

    assign in_ready_o = (state == FILL);
    assign blk_o      = data;
    assign last_slot  = (cnt == CNT_W'(NB_WORDS - 1));
    assign cnt_ext    = {1'b0, cnt};
    assign cnt_inc    = cnt_ext + {{CNT_W{1'b0}}, 1'b1};
    // A full last word leaves padding to the next slot, or to a whole pad block
    assign pad_next   = PAD_EN && in_last_i && !pad_placed && last_slot;
    assign spill      = PAD_EN && in_last_i && !pad_placed && !last_slot;

    // Next data register contents when a word is accepted into slot cnt
    always_comb begin
        fill_data = data;
        for (int unsigned s = 0; s < NB_WORDS; s++) begin
            if ((CNT_W+1)'(s) == cnt_ext) begin
                fill_data[BLOCK_W-1-s*WORD_W -: WORD_W] = padded_word;
            end else if (in_last_i && ((CNT_W+1)'(s) > cnt_ext)) begin
                fill_data[BLOCK_W-1-s*WORD_W -: WORD_W] =
                    (spill && ((CNT_W+1)'(s) == cnt_inc)) ? PAD_WORD : '0;
            end
        end
    end

    // Buffer state machine with registered block outputs
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= FILL;
            cnt         <= '0;
            data        <= '0;
            pad_pending <= 1'b0;
            blk_valid_o <= 1'b0;
            blk_last_o  <= 1'b0;
        end else if (clear_i) begin
            state       <= FILL;
            cnt         <= '0;
            data        <= '0;
            pad_pending <= 1'b0;
            blk_valid_o <= 1'b0;
            blk_last_o  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid_i) begin
                        data <= fill_data;
                        if (in_last_i) begin
                            state       <= HOLD;
                            blk_valid_o <= 1'b1;
                            pad_pending <= pad_next;
                            blk_last_o  <= !pad_next;
                        end else if (last_slot) begin
                            state       <= HOLD;
                            blk_valid_o <= 1'b1;
                            blk_last_o  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (blk_ready_i) begin
                        if (pad_pending) begin
                            state      <= PADBLK;
                            data       <= PAD_BLOCK;
                            blk_last_o <= 1'b1;
                        end else begin
                            state       <= FILL;
                            cnt         <= '0;
                            data        <= '0;
                            blk_valid_o <= 1'b0;
                            blk_last_o  <= 1'b0;
                        end
                    end
                end
                PADBLK: begin
                    if (blk_ready_i) begin
                        state       <= FILL;
                        cnt         <= '0;
                        data        <= '0;
                        pad_pending <= 1'b0;
                        blk_valid_o <= 1'b0;
                        blk_last_o  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_block_buffer.sv
// Scoreboard bench for ascon_block_buffer: one padded instance and one
// zero-fill instance, directed word sequences with hand-computed blocks.
module tb_ascon_block_buffer;

    typedef struct {
        logic [127:0] blk;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;

    logic [31:0]  in_word0 = '0, in_word1 = '0;
    logic         in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic         in_last0 = 1'b0, in_last1 = 1'b0;
    logic [2:0]   in_nbytes0 = '0, in_nbytes1 = '0;
    logic         in_ready0, in_ready1;
    logic [127:0] blk0, blk1;
    logic         blk_valid0, blk_valid1;
    logic         blk_last0, blk_last1;
    logic         blk_ready0 = 1'b1, blk_ready1 = 1'b1;

    int tests = 0;
    int fails = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    ascon_block_buffer #(.WORD_W(32), .NB_WORDS(4), .PAD_EN(1'b1)) u0 (
        .clock_i     (clk),
        .reset_i     (rst),
        .clear_i     (clr),
        .in_word_i   (in_word0),
        .in_valid_i  (in_valid0),
        .in_last_i   (in_last0),
        .in_nbytes_i (in_nbytes0),
        .in_ready_o  (in_ready0),
        .blk_o       (blk0),
        .blk_valid_o (blk_valid0),
        .blk_last_o  (blk_last0),
        .blk_ready_i (blk_ready0)
    );

    ascon_block_buffer #(.WORD_W(32), .NB_WORDS(4), .PAD_EN(1'b0)) u1 (
        .clock_i     (clk),
        .reset_i     (rst),
        .clear_i     (clr),
        .in_word_i   (in_word1),
        .in_valid_i  (in_valid1),
        .in_last_i   (in_last1),
        .in_nbytes_i (in_nbytes1),
        .in_ready_o  (in_ready1),
        .blk_o       (blk1),
        .blk_valid_o (blk_valid1),
        .blk_last_o  (blk_last1),
        .blk_ready_i (blk_ready1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect0(input logic [127:0] b, input logic l);
        exp_t e;
        e.blk = b;
        e.last = l;
        q0.push_back(e);
    endtask

    task automatic expect1(input logic [127:0] b, input logic l);
        exp_t e;
        e.blk = b;
        e.last = l;
        q1.push_back(e);
    endtask

    // Offer one word and hold it until the instance accepts it (bounded)
    task automatic send(input int inst, input logic [31:0] w, input logic l, input logic [2:0] nb);
        int n;
        logic rdy;
        n = 0;
        if (inst == 0) begin
            in_word0 = w; in_last0 = l; in_nbytes0 = nb; in_valid0 = 1'b1;
        end else begin
            in_word1 = w; in_last1 = l; in_nbytes1 = nb; in_valid1 = 1'b1;
        end
        forever begin
            @(negedge clk);
            rdy = (inst == 0) ? in_ready0 : in_ready1;
            if (rdy) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 100) begin
                check("send_timeout", 128'(n), 128'(0));
                break;
            end
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_last0 = 1'b0;
        in_last1 = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0) || (q1.size() != 0) || blk_valid0 || blk_valid1) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                check("drain_timeout", 128'(n), 128'(0));
                break;
            end
        end
    endtask

    // Monitor for the padded instance
    always @(negedge clk) begin
        if (!rst && !clr && blk_valid0 && blk_ready0) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL u0_unexpected_block: got %h expected none", blk0);
            end else begin
                e0 = q0.pop_front();
                check("u0_block", blk0, e0.blk);
                check("u0_last", 128'(blk_last0), 128'(e0.last));
            end
        end
    end

    // Monitor for the zero-fill instance
    always @(negedge clk) begin
        if (!rst && !clr && blk_valid1 && blk_ready1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL u1_unexpected_block: got %h expected none", blk1);
            end else begin
                e1 = q1.pop_front();
                check("u1_block", blk1, e1.blk);
                check("u1_last", 128'(blk_last1), 128'(e1.last));
            end
        end
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_blk", blk0, 128'h0);
        check("rst_valid", 128'(blk_valid0), 128'(0));
        check("rst_last", 128'(blk_last0), 128'(0));
        check("rst_in_ready", 128'(in_ready0), 128'(1));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full message on block boundary: data block then pad-only block
        expect0(128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0);
        expect0(128'h80000000_00000000_00000000_00000000, 1'b1);
        send(0, 32'h00010203, 1'b0, 3'd0);
        send(0, 32'h04050607, 1'b0, 3'd0);
        send(0, 32'h08090A0B, 1'b0, 3'd0);
        send(0, 32'h0C0D0E0F, 1'b1, 3'd4);

        // Partial last word
        expect0(128'h11223344_AABB8000_00000000_00000000, 1'b1);
        send(0, 32'h11223344, 1'b0, 3'd0);
        send(0, 32'hAABBCCDD, 1'b1, 3'd2);

        // Message ends on a word boundary inside the block
        expect0(128'hCAFEBABE_01234567_80000000_00000000, 1'b1);
        send(0, 32'hCAFEBABE, 1'b0, 3'd0);
        send(0, 32'h01234567, 1'b1, 3'd4);

        // Empty message
        expect0(128'h80000000_00000000_00000000_00000000, 1'b1);
        send(0, 32'hFFFFFFFF, 1'b1, 3'd0);

        // Byte count above the word size is clamped to a full word
        expect0(128'h55667788_80000000_00000000_00000000, 1'b1);
        send(0, 32'h55667788, 1'b1, 3'd7);

        // Partial last word in the final slot: no pad-only block
        expect0(128'h10000001_20000002_30000003_44556680, 1'b1);
        send(0, 32'h10000001, 1'b0, 3'd0);
        send(0, 32'h20000002, 1'b0, 3'd0);
        send(0, 32'h30000003, 1'b0, 3'd0);
        send(0, 32'h44556677, 1'b1, 3'd3);
        wait_drain();

        // Backpressure: block held stable with input stalled
        blk_ready0 = 1'b0;
        expect0(128'h11223344_AABB8000_00000000_00000000, 1'b1);
        send(0, 32'h11223344, 1'b0, 3'd0);
        send(0, 32'hAABBCCDD, 1'b1, 3'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_blk", blk0, 128'h11223344_AABB8000_00000000_00000000);
            check("bp_valid", 128'(blk_valid0), 128'(1));
            check("bp_in_ready", 128'(in_ready0), 128'(0));
        end
        @(posedge clk);
        #1 blk_ready0 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 128'(in_ready0), 128'(1));
        check("bp_release_valid", 128'(blk_valid0), 128'(0));

        // Clear wins over a consume in the same cycle
        blk_ready0 = 1'b0;
        send(0, 32'h99999999, 1'b1, 3'd4);
        @(posedge clk);
        #1;
        clr = 1'b1;
        blk_ready0 = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("clr_hold_valid", 128'(blk_valid0), 128'(0));
        check("clr_hold_in_ready", 128'(in_ready0), 128'(1));

        // Clear after two words, then a clean block
        send(0, 32'hDEADDEAD, 1'b0, 3'd0);
        send(0, 32'hBEEFBEEF, 1'b0, 3'd0);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check("clr_fill_valid", 128'(blk_valid0), 128'(0));
        check("clr_fill_blk", blk0, 128'h0);
        expect0(128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 1'b0);
        send(0, 32'hA0A0A0A0, 1'b0, 3'd0);
        send(0, 32'hB1B1B1B1, 1'b0, 3'd0);
        send(0, 32'hC2C2C2C2, 1'b0, 3'd0);
        send(0, 32'hD3D3D3D3, 1'b0, 3'd0);
        wait_drain();

        // Asynchronous reset after two words, then a clean block
        send(0, 32'h12121212, 1'b0, 3'd0);
        send(0, 32'h34343434, 1'b0, 3'd0);
        rst = 1'b1;
        #2;
        check("rst_mid_blk", blk0, 128'h0);
        check("rst_mid_valid", 128'(blk_valid0), 128'(0));
        check("rst_mid_in_ready", 128'(in_ready0), 128'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        expect0(128'h01010101_02020202_03030303_04040404, 1'b0);
        send(0, 32'h01010101, 1'b0, 3'd0);
        send(0, 32'h02020202, 1'b0, 3'd0);
        send(0, 32'h03030303, 1'b0, 3'd0);
        send(0, 32'h04040404, 1'b0, 3'd0);

        // Zero-fill instance: partial word, then full block ending on boundary
        expect1(128'hDE000000_00000000_00000000_00000000, 1'b1);
        send(1, 32'hDEADBEEF, 1'b1, 3'd1);
        expect1(128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b1);
        send(1, 32'h01020304, 1'b0, 3'd0);
        send(1, 32'h05060708, 1'b0, 3'd0);
        send(1, 32'h090A0B0C, 1'b0, 3'd0);
        send(1, 32'h0D0E0F10, 1'b1, 3'd4);

        wait_drain();
        repeat (5) @(posedge clk);
        #1;
        check("q0_empty", 128'(q0.size()), 128'(0));
        check("q1_empty", 128'(q1.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
